// File: rtl/sbox_generator_param_if.sv
// Bus bundle for sbox_generator_param: generation control, chaos samples and the read port.
// Define SBOX_INVERSE_EN to add the inverse-table read data.
interface sbox_generator_param_if #(
    parameter int SBOX_WIDTH  = 8,
    parameter int CHAOS_WIDTH = 32
);
    logic                   enable_bar;
    logic                   regen;
    logic [CHAOS_WIDTH-1:0] chaotic_signal_x1;
    logic [CHAOS_WIDTH-1:0] chaotic_signal_x2;
    logic [CHAOS_WIDTH-1:0] chaotic_signal_x3;
    logic [SBOX_WIDTH-1:0]  rd_addr;
    logic [SBOX_WIDTH-1:0]  rd_data;
    logic                   ready;
    logic                   busy;
    logic [SBOX_WIDTH:0]    fill_count;
`ifdef SBOX_INVERSE_EN
    logic [SBOX_WIDTH-1:0]  inv_rd_data;
`endif

    modport master (
        output enable_bar, regen, chaotic_signal_x1, chaotic_signal_x2, chaotic_signal_x3, rd_addr,
`ifdef SBOX_INVERSE_EN
        input  inv_rd_data,
`endif
        input  rd_data, ready, busy, fill_count
    );

    modport slave (
        input  enable_bar, regen, chaotic_signal_x1, chaotic_signal_x2, chaotic_signal_x3, rd_addr,
`ifdef SBOX_INVERSE_EN
        output inv_rd_data,
`endif
        output rd_data, ready, busy, fill_count
    );
endinterface

// File: rtl/sbox_generator_param.sv
// Bijective 2^W-entry S-box builder fed by a chaos stream; used-value bitmap plus linear probing.
// Define SBOX_INVERSE_EN to also build the inverse table and drive inv_rd_data.
module sbox_generator_param #(
    parameter int SBOX_WIDTH  = 8,
    parameter int CHAOS_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    sbox_generator_param_if.slave bus
);
    localparam int W     = SBOX_WIDTH;
    localparam int DEPTH = 1 << W;

    typedef enum logic [1:0] {FILL, PROBE, DONE} state_t;

    state_t            state, state_n;
    logic [W-1:0]      index;
    logic [W-1:0]      probe_ptr, probe_n;
    logic [DEPTH-1:0]  bitmap;
    logic [W:0]        fill_count;
    logic [W-1:0]      cand;
    logic [W-1:0]      wr_val;
    logic              wr_en;
    logic              clr;
    logic              last;
    logic [W-1:0]      sbox [DEPTH];
    logic [W-1:0]      rd_data;

    assign cand = bus.chaotic_signal_x1[W-1:0] ^ bus.chaotic_signal_x2[W-1:0]
                ^ bus.chaotic_signal_x3[W-1:0];
    assign last = (index == {W{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) state <= FILL;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        probe_n = probe_ptr;
        wr_en   = 1'b0;
        wr_val  = cand;
        clr     = 1'b0;
        case (state)
            FILL: if (!bus.enable_bar) begin
                if (!bitmap[cand]) begin
                    wr_en = 1'b1;
                end else begin
                    probe_n = cand + 1'b1;
                    state_n = PROBE;
                end
            end
            PROBE: if (!bus.enable_bar) begin
                if (!bitmap[probe_ptr]) begin
                    wr_en   = 1'b1;
                    wr_val  = probe_ptr;
                    state_n = FILL;
                end else begin
                    probe_n = probe_ptr + 1'b1;
                end
            end
            DONE: if (bus.regen) begin
                clr     = 1'b1;
                state_n = FILL;
            end
            default: state_n = FILL;
        endcase
        if (wr_en && last) state_n = DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index      <= '0;
            probe_ptr  <= '0;
            bitmap     <= '0;
            fill_count <= '0;
            rd_data    <= '0;
        end else begin
            probe_ptr <= probe_n;
            rd_data   <= sbox[bus.rd_addr];
            if (wr_en) begin
                bitmap[wr_val] <= 1'b1;
                index          <= index + 1'b1;
                fill_count     <= fill_count + 1'b1;
            end
            if (clr) begin
                bitmap     <= '0;
                index      <= '0;
                fill_count <= '0;
            end
        end
    end

    // Table storage is deliberately left unreset; only a qualified write touches it.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) sbox[index] <= wr_val;
    end

`ifdef SBOX_INVERSE_EN
    logic [W-1:0] inv [DEPTH];
    logic [W-1:0] inv_rd_data;

    always_ff @(posedge clk) begin
        if (!reset && wr_en) inv[wr_val] <= index;
    end

    always_ff @(posedge clk) begin
        if (reset) inv_rd_data <= '0;
        else       inv_rd_data <= inv[bus.rd_addr];
    end

    assign bus.inv_rd_data = inv_rd_data;
`endif

    assign bus.rd_data    = rd_data;
    assign bus.fill_count = fill_count;
    assign bus.ready      = (state == DONE);
    assign bus.busy       = (state != DONE);
endmodule
